// File: rtl/kl_pipe_pkg.sv
// kl_pipe_pkg: shared widths, control-bundle field offsets and helpers for the issue stage
package kl_pipe_pkg;

    localparam int CTRL_W  = 22;
    localparam int DATA_W  = 16;
    localparam int NREG    = 8;
    localparam int REG_W   = 3;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    localparam int OPC_LSB   = 19;
    localparam int PC_LSB    = 11;
    localparam int ASEL_BIT  = 10;
    localparam int BSEL_BIT  = 9;
    localparam int LOADS_BIT = 8;
    localparam int ALUOP_LSB = 6;
    localparam int SHIFT_LSB = 4;
    localparam int WRITE_BIT = 3;
    localparam int WNUM_LSB  = 0;

    localparam int USED_RM = 2;
    localparam int USED_RN = 1;
    localparam int USED_RD = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  regnum_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(CNT_MAX);

    typedef struct packed {
        ctrl_t control;
        data_t a;
        data_t b;
        data_t c;
        data_t sximm;
    } issue_t;

    function automatic logic ctrl_write(input ctrl_t c);
        return c[WRITE_BIT];
    endfunction

    function automatic regnum_t ctrl_wnum(input ctrl_t c);
        return c[WNUM_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register saturating pending-write counters with sticky misuse flag
module issue_scoreboard
    import kl_pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  regnum_t              inc_num,
    input  logic                 dec,
    input  regnum_t              dec_num,
    input  logic                 fl_dec,
    input  regnum_t              fl_num,
    output cnt_t [NREG-1:0]      pend,
    output logic                 err
);

    cnt_t [NREG-1:0] pend_nxt;
    logic [NREG-1:0] bad;

    // Net change per register: one issue increment against up to two retire/flush decrements, clamped to 0..CNT_MAX
    always_comb begin
        pend_nxt = pend;
        bad      = '0;
        for (int r = 0; r < NREG; r++) begin
            int s;
            s = int'(pend[r])
              + ((inc    && inc_num == regnum_t'(r)) ? 1 : 0)
              - ((dec    && dec_num == regnum_t'(r)) ? 1 : 0)
              - ((fl_dec && fl_num  == regnum_t'(r)) ? 1 : 0);
            bad[r]      = (s < 0) || (s > CNT_MAX);
            pend_nxt[r] = (s < 0) ? '0 : (s > CNT_MAX) ? CNT_FULL : cnt_t'(s);
        end
    end

    // Counters plus an error flag that stays set until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            err  <= 1'b0;
        end else begin
            pend <= pend_nxt;
            err  <= err | (|bad);
        end
    end

endmodule

// File: rtl/pipeline_1_issue.sv
// pipeline_1_issue: single-entry issue stage with operand read and pending-write hazard scoreboard
module pipeline_1_issue
    import kl_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_in,
    input  logic [REG_W-1:0]  num_Rm_in,
    input  logic [REG_W-1:0]  num_Rn_in,
    input  logic [REG_W-1:0]  num_Rd_in,
    input  logic [2:0]        used_in,
    input  logic [DATA_W-1:0] sximm_in,
    output logic [REG_W-1:0]  rf_addr_a,
    output logic [REG_W-1:0]  rf_addr_b,
    output logic [REG_W-1:0]  rf_addr_c,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic [DATA_W-1:0] rf_data_c,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_num,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_control,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B,
    output logic [DATA_W-1:0] out_C,
    output logic [DATA_W-1:0] out_sximm,
    output logic              hazard_stall,
    output logic              sb_err
);

    cnt_t [NREG-1:0] pend;
    logic            hazard;
    logic            issue;
    logic            fl_dec;

    assign rf_addr_a = num_Rm_in;
    assign rf_addr_b = num_Rn_in;
    assign rf_addr_c = num_Rd_in;

    // Stall on any read of a register with writes in flight, or on a write that would overflow its counter
    always_comb begin
        hazard = (used_in[USED_RM] && pend[num_Rm_in] != '0)
              || (used_in[USED_RN] && pend[num_Rn_in] != '0)
              || (used_in[USED_RD] && pend[num_Rd_in] != '0)
              || (ctrl_write(control_in) && pend[ctrl_wnum(control_in)] == CNT_FULL);
    end

    assign in_ready     = !hazard && (!out_valid || out_ready) && !flush;
    assign issue        = in_valid && in_ready;
    assign hazard_stall = in_valid && hazard;
    assign fl_dec       = flush && out_valid && ctrl_write(out_control);

    issue_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (issue && ctrl_write(control_in)),
        .inc_num (ctrl_wnum(control_in)),
        .dec     (wb_valid),
        .dec_num (wb_num),
        .fl_dec  (fl_dec),
        .fl_num  (ctrl_wnum(out_control)),
        .pend    (pend),
        .err     (sb_err)
    );

    // Output register: load on issue, drop on consume or flush, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_control <= '0;
            out_A       <= '0;
            out_B       <= '0;
            out_C       <= '0;
            out_sximm   <= '0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_control <= control_in;
            out_A       <= used_in[USED_RM] ? rf_data_a : '0;
            out_B       <= used_in[USED_RN] ? rf_data_b : '0;
            out_C       <= used_in[USED_RD] ? rf_data_c : '0;
            out_sximm   <= sximm_in;
        end else if (flush || out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_1_issue.sv
// tb_pipeline_1_issue: directed scoreboard bench for the issue stage
module tb_pipeline_1_issue;
    import kl_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [21:0] control_in;
    logic [2:0]  num_Rm_in, num_Rn_in, num_Rd_in, used_in;
    logic [15:0] sximm_in;
    logic [2:0]  rf_addr_a, rf_addr_b, rf_addr_c;
    logic [15:0] rf_data_a, rf_data_b, rf_data_c;
    logic        wb_valid, flush, out_valid, out_ready, hazard_stall, sb_err;
    logic [2:0]  wb_num;
    logic [21:0] out_control;
    logic [15:0] out_A, out_B, out_C, out_sximm;
    logic [7:0]  pc_cnt = 8'h10;

    issue_t q[$];
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipeline_1_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
        .num_Rd_in(num_Rd_in), .used_in(used_in), .sximm_in(sximm_in),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_c(rf_addr_c),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .rf_data_c(rf_data_c),
        .wb_valid(wb_valid), .wb_num(wb_num), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_control(out_control),
        .out_A(out_A), .out_B(out_B), .out_C(out_C), .out_sximm(out_sximm),
        .hazard_stall(hazard_stall), .sb_err(sb_err)
    );

    function automatic logic [15:0] rf(input logic [2:0] a);
        return 16'h1357 ^ ({13'd0, a} * 16'h0F11);
    endfunction

    assign rf_data_a = rf(rf_addr_a);
    assign rf_data_b = rf(rf_addr_b);
    assign rf_data_c = rf(rf_addr_c);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pchk(input int r, input logic [1:0] exp);
        chk($sformatf("pend[%0d]", r), dut.u_sb.pend[r], exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] opc, input logic wr, input logic [2:0] wn,
                         input logic [2:0] rm, input logic [2:0] rn, input logic [2:0] rd,
                         input logic [2:0] used, input logic [15:0] imm);
        in_valid   = v;
        control_in = {opc, pc_cnt, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, wr, wn};
        pc_cnt     = pc_cnt + 8'd1;
        num_Rm_in  = rm;
        num_Rn_in  = rn;
        num_Rd_in  = rd;
        used_in    = used;
        sximm_in   = imm;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 16'h0);
    endtask

    function automatic issue_t exp_of();
        issue_t e;
        e.control = control_in;
        e.a       = used_in[2] ? rf(num_Rm_in) : 16'h0;
        e.b       = used_in[1] ? rf(num_Rn_in) : 16'h0;
        e.c       = used_in[0] ? rf(num_Rd_in) : 16'h0;
        e.sximm   = sximm_in;
        return e;
    endfunction

    task automatic cyc(input logic exp_rdy, input logic exp_stall);
        @(negedge clk);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) chk("out_bundle", {out_control, out_A, out_B, out_C, out_sximm}, q[0]);
        chk("in_ready", in_ready, exp_rdy);
        chk("hazard_stall", hazard_stall, exp_stall);
        if (q.size() != 0 && (flush || out_ready)) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back(exp_of());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        out_ready = 1'b1;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_num    = 3'd0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bundle", {out_control, out_A, out_B, out_C, out_sximm}, 128'h0);
        chk("rst_sb_err", sb_err, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) pchk(r, 2'd0);

        // MOV R1,#5 then ADD R2,R1,R0 stalls until R1 retires
        drive(1'b1, 3'b110, 1'b1, 3'd1, 3'd0, 3'd0, 3'd0, 3'b000, 16'd5);
        cyc(1'b1, 1'b0);
        pchk(1, 2'd1);
        drive(1'b1, 3'b101, 1'b1, 3'd2, 3'd0, 3'd1, 3'd2, 3'b110, 16'd0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        wb_valid = 1'b1;
        wb_num   = 3'd1;
        cyc(1'b0, 1'b1);
        wb_valid = 1'b0;
        cyc(1'b1, 1'b0);
        idle();
        cyc(1'b1, 1'b0);
        pchk(1, 2'd0);
        pchk(2, 2'd1);
        wb_valid = 1'b1;
        wb_num   = 3'd2;
        cyc(1'b1, 1'b0);
        wb_valid = 1'b0;
        pchk(2, 2'd0);

        // Backpressure: held output stays stable for four cycles
        out_ready = 1'b0;
        drive(1'b1, 3'b011, 1'b0, 3'd0, 3'd5, 3'd6, 3'd7, 3'b101, 16'hBEEF);
        cyc(1'b1, 1'b0);
        drive(1'b1, 3'b010, 1'b0, 3'd0, 3'd1, 3'd2, 3'd3, 3'b111, 16'h1234);
        repeat (4) cyc(1'b0, 1'b0);
        out_ready = 1'b1;
        cyc(1'b1, 1'b0);
        idle();
        cyc(1'b1, 1'b0);

        // Three writes to R3 saturate its counter; a fourth stalls
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b110, 1'b1, 3'd3, 3'd0, 3'd0, 3'd0, 3'b000, 16'(i));
            cyc(1'b1, 1'b0);
        end
        pchk(3, 2'd3);
        drive(1'b1, 3'b110, 1'b1, 3'd3, 3'd0, 3'd0, 3'd0, 3'b000, 16'd9);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("sb_err_sat", sb_err, 1'b0);
        idle();
        wb_valid = 1'b1;
        wb_num   = 3'd3;
        repeat (3) cyc(1'b1, 1'b0);
        wb_valid = 1'b0;
        pchk(3, 2'd0);
        chk("sb_err_drain", sb_err, 1'b0);

        // Issue and retire of R4 in the same cycle leaves the count unchanged
        drive(1'b1, 3'b110, 1'b1, 3'd4, 3'd0, 3'd0, 3'd0, 3'b000, 16'd4);
        cyc(1'b1, 1'b0);
        pchk(4, 2'd1);
        drive(1'b1, 3'b110, 1'b1, 3'd4, 3'd0, 3'd0, 3'd0, 3'b000, 16'd44);
        wb_valid = 1'b1;
        wb_num   = 3'd4;
        cyc(1'b1, 1'b0);
        idle();
        wb_valid = 1'b0;
        pchk(4, 2'd1);
        wb_valid = 1'b1;
        cyc(1'b1, 1'b0);
        wb_valid = 1'b0;
        pchk(4, 2'd0);

        // Flush of a held write to R5 releases its counter and blocks issue
        out_ready = 1'b0;
        drive(1'b1, 3'b110, 1'b1, 3'd5, 3'd0, 3'd0, 3'd0, 3'b000, 16'd55);
        cyc(1'b1, 1'b0);
        pchk(5, 2'd1);
        drive(1'b1, 3'b000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 16'd0);
        flush = 1'b1;
        cyc(1'b0, 1'b0);
        flush = 1'b0;
        idle();
        pchk(5, 2'd0);
        cyc(1'b1, 1'b0);
        out_ready = 1'b1;

        // NOP issues normally and leaves the scoreboard untouched
        drive(1'b1, 3'b000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 16'h0);
        cyc(1'b1, 1'b0);
        idle();
        cyc(1'b1, 1'b0);
        for (int r = 0; r < 8; r++) pchk(r, 2'd0);

        // Retire of an idle register sets a sticky error
        chk("sb_err_pre", sb_err, 1'b0);
        wb_valid = 1'b1;
        wb_num   = 3'd6;
        cyc(1'b1, 1'b0);
        wb_valid = 1'b0;
        chk("sb_err_set", sb_err, 1'b1);
        pchk(6, 2'd0);
        repeat (3) cyc(1'b1, 1'b0);
        chk("sb_err_sticky", sb_err, 1'b1);

        // Asynchronous reset mid-hold discards everything
        out_ready = 1'b0;
        drive(1'b1, 3'b110, 1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 3'b000, 16'd77);
        cyc(1'b1, 1'b0);
        chk("held_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_bundle", {out_control, out_A, out_B, out_C, out_sximm}, 128'h0);
        chk("arst_sb_err", sb_err, 1'b0);
        pchk(7, 2'd0);
        q.delete();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cyc(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pipeline_1_issue.md
PIPELINE_1_ISSUE -- requirements
Module: pipeline_1_issue

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  decoded instruction present; in_ready  out  1  stage accepts it this cycle.
REQ-004 SHALL have ports: control_in  in  22  decode bundle {opcode[21:19], PC[18:11], asel[10], bsel[9], loads[8], ALUop[7:6], shift[5:4], write[3], writenum[2:0]}.
REQ-005 SHALL have ports: num_Rm_in, num_Rn_in, num_Rd_in  in  3 each; used_in  in  3  {Rm,Rn,Rd} operand-used flags; sximm_in  in  16.
REQ-006 SHALL have ports: rf_addr_a/b/c  out  3 each  (driven from Rm/Rn/Rd); rf_data_a/b/c  in  16 each  combinational register-file read data.
REQ-007 SHALL have ports: wb_valid  in  1; wb_num  in  3  one register write retired downstream this cycle.
REQ-008 SHALL have ports: flush  in  1  discard the held output instruction.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_control  out  22; out_A, out_B, out_C, out_sximm  out  16 each.
REQ-010 SHALL have ports: hazard_stall  out  1  in_valid blocked by scoreboard; sb_err  out  1  sticky underflow/overflow flag.

Function
REQ-011 SHALL keep one output register (control, A=Rm data, B=Rn data, C=Rd data, sximm) plus out_valid.
REQ-012 SHALL keep per-register 2-bit pending-write counters pend[0..7].
REQ-013 SHALL compute hazard = OR over used flags set of (pend[num]!=0), plus (write bit set AND pend[writenum]==3).
REQ-014 SHALL drive in_ready = !hazard && (!out_valid || out_ready) && !flush; issue = in_valid && in_ready.
REQ-015 SHALL, on issue, load output register next edge with control_in, rf_data_a/b/c, sximm_in, and set out_valid; latency input-to-output exactly 1 cycle.
REQ-016 SHALL clear out_valid on out_ready && out_valid without issue; SHALL hold all out_* stable while out_valid && !out_ready.
REQ-017 SHALL zero rf data for operands whose used flag is 0 (out value 16'h0000).
REQ-018 SHALL increment pend[writenum] on issue when write bit=1; decrement pend[wb_num] on wb_valid.
REQ-019 SHALL leave the counter unchanged when increment and decrement hit the same register in one cycle.
REQ-020 SHALL evaluate hazard from registered counters only (no same-cycle writeback bypass).
REQ-021 SHALL, on flush, clear out_valid next edge and decrement pend[out_control writenum] if the held instruction had out_valid=1 and write=1; flush blocks issue that cycle.
REQ-022 SHALL, on decrement of a zero counter, hold 0 and set sb_err; on increment of 3, hold 3 and set sb_err (unreachable under REQ-013).
REQ-023 SHALL assert hazard_stall = in_valid && hazard (combinational).
REQ-024 SHALL treat NOP (opcode 000, used=000, write=0) as normal issue with no scoreboard effect.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear out_valid, all pend counters, sb_err, and all out_* data to 0.
REQ-026 SHALL discard a held instruction when reset asserts mid-operation; no state survives.

Structure
REQ-027 SHALL place control-bundle field offsets, width 22, register count 8, and counter max 3 in shared package kl_pipe_pkg.
REQ-028 SHALL implement the counters as sub-module issue_scoreboard (inc/dec ports, pend vector out, err out).

Verification
REQ-029 SHALL test: MOV R1,#5 issued then ADD R2,R1,R0 presented -> hazard_stall=1 until wb_valid wb_num=1, issue on cycle after wb.
REQ-030 SHALL test: out_ready=0 for 4 cycles with out_valid=1 -> out_* unchanged, in_ready=0.
REQ-031 SHALL test: three writes to R3 issued without wb -> pend[3]=3, fourth write to R3 stalls, sb_err stays 0.
REQ-032 SHALL test: issue write R4 and wb R4 same cycle with pend[4]=1 -> pend[4] stays 1.
REQ-033 SHALL test: flush while holding write R5 (pend[5]=1) -> out_valid=0, pend[5]=0 next cycle.
REQ-034 SHALL test: wb_valid wb_num=6 with pend[6]=0 -> sb_err=1 sticky until rst_n low.
